// File: rtl/seven_seg_display_ctrl.sv
// Registered driver for NUM_DIGITS active-low 7-segment digits with
// per-digit enable, blinking and circular scrolling of the captured values.
module seven_seg_display_ctrl #(
   parameter int unsigned NUM_DIGITS = 8,
   parameter int unsigned BLINK_DIV  = 25_000_000,
   parameter int unsigned SCROLL_DIV = 12_500_000
) (
   input  logic                         CLOCK_50_I,
   input  logic                         Reset,
   input  logic                         load_i,
   input  logic [NUM_DIGITS-1:0][4:0]   hex_values_i,
   input  logic [NUM_DIGITS-1:0]        blink_mask_i,
   input  logic                         scroll_en_i,
   output logic [NUM_DIGITS-1:0][6:0]   SEVEN_SEGMENT_N_O,
   output logic                         scroll_wrap_o
);

   localparam int unsigned BW = $clog2(BLINK_DIV);
   localparam int unsigned SW = $clog2(SCROLL_DIV);
   localparam int unsigned OW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [BW-1:0] BLINK_MAX  = BW'(BLINK_DIV - 1);
   localparam logic [SW-1:0] SCROLL_MAX = SW'(SCROLL_DIV - 1);
   localparam logic [OW-1:0] OFF_MAX    = OW'(NUM_DIGITS - 1);

   function automatic logic [6:0] hex2seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   logic [NUM_DIGITS-1:0][4:0] val_q, val_d;
   logic [NUM_DIGITS-1:0]      mask_q, mask_d;
   logic [BW-1:0]              blink_cnt_q, blink_cnt_d;
   logic                       blink_phase_q, blink_phase_d;
   logic [SW-1:0]              scroll_cnt_q, scroll_cnt_d;
   logic [OW-1:0]              offset_q, offset_d;
   logic                       wrap_q, wrap_d;
   logic [NUM_DIGITS-1:0][6:0] seg_q, seg_d;

   // Load takes priority over both counters, so a load on a scroll wrap
   // restarts at offset 0 without a wrap pulse.
   always_comb begin
      val_d         = val_q;
      mask_d        = mask_q;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      scroll_cnt_d  = scroll_cnt_q;
      offset_d      = offset_q;
      wrap_d        = 1'b0;
      if (load_i) begin
         val_d         = hex_values_i;
         mask_d        = blink_mask_i;
         blink_cnt_d   = '0;
         blink_phase_d = 1'b1;
         scroll_cnt_d  = '0;
         offset_d      = '0;
      end else begin
         if (blink_cnt_q == BLINK_MAX) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
         end
         if (!scroll_en_i) begin
            scroll_cnt_d = '0;
            offset_d     = '0;
         end else if (scroll_cnt_q == SCROLL_MAX) begin
            scroll_cnt_d = '0;
            if (offset_q == OFF_MAX) begin
               offset_d = '0;
               wrap_d   = 1'b1;
            end else begin
               offset_d = offset_q + OW'(1);
            end
         end else begin
            scroll_cnt_d = scroll_cnt_q + SW'(1);
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         logic [OW:0]   sum;
         logic [OW-1:0] src;
         logic [4:0]    ent;
         logic          blank;
         assign sum   = {1'b0, offset_q} + (OW+1)'(gi);
         assign src   = (sum >= (OW+1)'(NUM_DIGITS)) ? OW'(sum - (OW+1)'(NUM_DIGITS))
                                                     : sum[OW-1:0];
         assign ent   = val_q[src];
         assign blank = ~ent[4] | (mask_q[src] & ~blink_phase_q);
         assign seg_d[gi] = blank ? 7'h7F : hex2seg(ent[3:0]);
      end
   endgenerate

   always_ff @(posedge CLOCK_50_I) begin
      if (Reset) begin
         val_q         <= '0;
         mask_q        <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b1;
         scroll_cnt_q  <= '0;
         offset_q      <= '0;
         wrap_q        <= 1'b0;
         seg_q         <= '1;
      end else begin
         val_q         <= val_d;
         mask_q        <= mask_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         scroll_cnt_q  <= scroll_cnt_d;
         offset_q      <= offset_d;
         wrap_q        <= wrap_d;
         seg_q         <= seg_d;
      end
   end

   assign SEVEN_SEGMENT_N_O = seg_q;
   assign scroll_wrap_o     = wrap_q;

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// Directed bench for seven_seg_display_ctrl: 4 digits, short blink/scroll periods.
module tb_seven_seg_display_ctrl;

   localparam int N = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              load;
   logic              scroll_en;
   logic [N-1:0][4:0] hexv;
   logic [N-1:0]      mask;
   logic [N-1:0][6:0] segs;
   logic              wrap;

   int n_total = 0;
   int n_bad   = 0;

   logic [27:0] scr_exp [4];
   logic [6:0]  hex_tbl [16];

   always #5 clk = ~clk;

   seven_seg_display_ctrl #(
      .NUM_DIGITS (4),
      .BLINK_DIV  (4),
      .SCROLL_DIV (3)
   ) dut (
      .CLOCK_50_I        (clk),
      .Reset             (rst),
      .load_i            (load),
      .hex_values_i      (hexv),
      .blink_mask_i      (mask),
      .scroll_en_i       (scroll_en),
      .SEVEN_SEGMENT_N_O (segs),
      .scroll_wrap_o     (wrap)
   );

   task automatic chk(input string tag, input logic [27:0] got, input logic [27:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%07h exp=%07h", tag, got, exp);
      end else begin
         $display("ok   %s %07h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [19:0] v, input logic [3:0] m, input logic se);
      hexv      = v;
      mask      = m;
      scroll_en = se;
      load      = 1'b1;
      tick();
      load      = 1'b0;
   endtask

   localparam logic [19:0] V2 = {5'h0F, 5'h1A, 5'h11, 5'h10};
   localparam logic [19:0] V4 = {5'h14, 5'h13, 5'h12, 5'h11};
   localparam logic [27:0] BLANK = 28'hFFF_FFFF;

   initial begin
      int off;
      // digit i shows value (i+off)%4 of {1,2,3,4} -> segs 79,24,30,19
      scr_exp[0] = {7'h19, 7'h30, 7'h24, 7'h79};
      scr_exp[1] = {7'h79, 7'h19, 7'h30, 7'h24};
      scr_exp[2] = {7'h24, 7'h79, 7'h19, 7'h30};
      scr_exp[3] = {7'h30, 7'h24, 7'h79, 7'h19};
      hex_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

      rst = 1'b1; load = 1'b0; scroll_en = 1'b0; hexv = '0; mask = '0;

      // 1: reset
      repeat (3) tick();
      chk("rst_segs", segs, BLANK);
      chk("rst_wrap", {27'b0, wrap}, 28'h0);
      rst = 1'b0;
      tick();
      chk("post_rst_segs", segs, BLANK);

      // 2: static load, two-cycle latency
      do_load(V2, 4'b0000, 1'b0);
      chk("static_lat1", segs, BLANK);
      for (int j = 0; j < 6; j++) begin
         tick();
         chk("static", segs, {7'h7F, 7'h08, 7'h79, 7'h40});
      end

      // all sixteen hex codes on digit 0
      for (int h = 0; h < 16; h++) begin
         do_load({15'h0, 1'b1, 4'(h)}, 4'b0000, 1'b0);
         tick();
         chk($sformatf("hex_%0h", h), segs, {7'h7F, 7'h7F, 7'h7F, hex_tbl[h]});
      end

      // 3: blink digit 0, 4 cycles on / 4 off
      do_load(V2, 4'b0001, 1'b0);
      for (int j = 1; j <= 16; j++) begin
         tick();
         if ((((j - 1) / 4) % 2) == 0)
            chk($sformatf("blink_%0d", j), segs, {7'h7F, 7'h08, 7'h79, 7'h40});
         else
            chk($sformatf("blink_%0d", j), segs, {7'h7F, 7'h08, 7'h79, 7'h7F});
      end

      // 4: scroll, 3 cycles per step, wrap pulse with offset 3->0
      do_load(V4, 4'b0000, 1'b1);
      for (int j = 1; j <= 15; j++) begin
         tick();
         off = ((j - 1) / 3) % 4;
         chk($sformatf("scroll_%0d", j), segs, scr_exp[off]);
         chk($sformatf("scroll_wrap_%0d", j), {27'b0, wrap}, {27'b0, (j == 12)});
      end

      // 5: load coincident with the offset 3->0 wrap
      do_load(V4, 4'b0000, 1'b1);
      repeat (11) tick();
      do_load(V4, 4'b0000, 1'b1);
      chk("ldwrap_wrap", {27'b0, wrap}, 28'h0);
      chk("ldwrap_segs", segs, scr_exp[3]);
      for (int j = 1; j <= 4; j++) begin
         tick();
         chk($sformatf("ldwrap_%0d", j), segs, scr_exp[(j <= 3) ? 0 : 1]);
         chk($sformatf("ldwrap_w_%0d", j), {27'b0, wrap}, 28'h0);
      end

      // 6: reset mid-scroll at offset 2
      do_load(V4, 4'b0000, 1'b1);
      repeat (7) tick();
      chk("mid_off2", segs, scr_exp[2]);
      rst = 1'b1;
      tick();
      chk("mid_rst_segs", segs, BLANK);
      chk("mid_rst_wrap", {27'b0, wrap}, 28'h0);
      rst = 1'b0;
      tick();
      chk("mid_rst_hold", segs, BLANK);
      do_load(V4, 4'b0000, 1'b1);
      tick();
      chk("reload_off0", segs, scr_exp[0]);
      repeat (3) tick();
      chk("reload_off1", segs, scr_exp[1]);

      // scroll disable returns offset to 0
      scroll_en = 1'b0;
      tick();
      chk("dis_lag", segs, scr_exp[1]);
      tick();
      chk("dis_off0", segs, scr_exp[0]);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
